// File: rtl/ray_dir_gen.sv
// Raster pixel scanner that emits one unnormalized primary-ray direction per pixel
// as 27-bit floats (1 sign, 8 exponent bias 127, 18 mantissa), under a valid/ready handshake.
module ray_dir_gen #(
    parameter int          H_RES   = 640,
    parameter int          V_RES   = 480,
    parameter logic [26:0] FOCAL_Z = 27'h21D0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [26:0] o_dir_x,
    output logic [26:0] o_dir_y,
    output logic [26:0] o_dir_z,
    output logic [9:0]  o_px,
    output logic [9:0]  o_py,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_frame_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_next;
    logic              load, valid_next, done_next, last_next;
    logic [9:0]        px_next, py_next;
    logic signed [11:0] xi, yi;

    // Exact conversion: the integer magnitude never exceeds 11 significant bits,
    // so it always fits the 18-bit mantissa without rounding.
    function automatic logic [26:0] int_to_float(input logic signed [11:0] v);
        logic [11:0] mag;
        logic [3:0]  p;
        logic [17:0] mant;
        logic [26:0] result;
        mag = v[11] ? $unsigned(-v) : $unsigned(v);
        p = '0;
        for (int i = 0; i < 12; i++) begin
            if (mag[i]) p = 4'(i);
        end
        mant = {6'b0, mag} << (5'd18 - 5'(p));
        result = {v[11], 8'd127 + 8'(p), mant};
        if (mag == '0) result = '0;
        return result;
    endfunction

    always_comb begin
        state_next = state;
        load       = 1'b0;
        valid_next = o_valid;
        done_next  = 1'b0;
        px_next    = o_px;
        py_next    = o_py;
        case (state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_next = RUN;
                    load       = 1'b1;
                    valid_next = 1'b1;
                    px_next    = '0;
                    py_next    = '0;
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end else if (o_valid && i_ready) begin
                    if (o_last) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (o_px == 10'(H_RES - 1)) begin
                            px_next = '0;
                            py_next = o_py + 10'd1;
                        end else begin
                            px_next = o_px + 10'd1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pixel centres are symmetric about the optical axis, hence the doubled, offset coordinates.
    always_comb begin
        xi        = $signed({1'b0, px_next, 1'b0}) - 12'(H_RES - 1);
        yi        = 12'(V_RES - 1) - $signed({1'b0, py_next, 1'b0});
        last_next = (px_next == 10'(H_RES - 1)) && (py_next == 10'(V_RES - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            o_valid      <= 1'b0;
            o_dir_x      <= '0;
            o_dir_y      <= '0;
            o_dir_z      <= '0;
            o_px         <= '0;
            o_py         <= '0;
            o_last       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_next;
            o_valid      <= valid_next;
            o_frame_done <= done_next;
            o_last       <= valid_next & (load ? last_next : o_last);
            if (load) begin
                o_px    <= px_next;
                o_py    <= py_next;
                o_dir_x <= int_to_float(xi);
                o_dir_y <= int_to_float(yi);
                o_dir_z <= FOCAL_Z;
            end
        end
    end

    assign o_busy = (state == RUN);

endmodule
